// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type, default timing values and column-drive patterns for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  localparam int DEF_SCAN_DIV = 1000;
  localparam int DEF_DEBOUNCE_CNT = 4;
  localparam logic [3:0] COL0_DRV = 4'b1110;
  localparam logic [3:0] COL1_DRV = 4'b1101;
  localparam logic [3:0] COL2_DRV = 4'b1011;
  localparam logic [3:0] COL3_DRV = 4'b0111;
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return c == 2'd0 ? COL0_DRV : c == 2'd1 ? COL1_DRV : c == 2'd2 ? COL2_DRV : COL3_DRV;
  endfunction
  function automatic logic [1:0] lowest_low(input logic [3:0] lo);
    return lo[0] ? 2'd0 : lo[1] ? 2'd1 : lo[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer bringing the asynchronous row lines into the clock domain
module keypad_sync #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_q, sync_q;
  // first stage may go metastable; second stage gives it a cycle to settle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with per-dwell debounce, one Valid pulse per confirmed press
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Rows,
  output logic [3:0] Cols,
  output logic [3:0] Code,
  output logic       Valid,
  output logic       Pressed
);
  localparam logic [15:0] DWELL_MAX = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_MAX   = 4'(DEBOUNCE_CNT);
  logic [3:0]  rows_s, lo;
  logic [15:0] dwell_q, dwell_d;
  state_t      state_q, state_d;
  logic [1:0]  col_q, col_d, row_q, row_d, col_nx, first_row;
  logic [3:0]  deb_q, deb_d, deb_inc, code_q, code_d;
  logic        valid_q, valid_d, pressed_q, pressed_d;
  logic        sample, hit;
  keypad_sync #(.WIDTH(4), .RST_VAL(4'b1111)) u_sync (
    .clk(Clock),
    .rst(Reset),
    .d  (Rows),
    .q  (rows_s)
  );
  assign lo        = ~rows_s;
  assign hit       = lo[row_q];
  assign first_row = lowest_low(lo);
  assign sample    = dwell_q == DWELL_MAX;
  assign col_nx    = col_q + 2'd1;
  assign deb_inc   = deb_q + 4'd1;
  // dwell timer: one sample point every SCAN_DIV cycles
  always_comb dwell_d = sample ? 16'd0 : dwell_q + 16'd1;
  // scan/debounce FSM; every decision is taken only at a sample point
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    deb_d     = deb_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    if (sample) begin
      case (state_q)
        SCAN:
          if (|lo) begin
            row_d = first_row;
            deb_d = 4'd1;
            if (DEB_MAX == 4'd1) begin
              state_d   = HELD;
              code_d    = {first_row, col_q};
              valid_d   = 1'b1;
              pressed_d = 1'b1;
            end else state_d = DEBOUNCE;
          end else col_d = col_nx;
        DEBOUNCE:
          if (!hit) begin
            state_d = SCAN;
            col_d   = col_nx;
          end else if (deb_inc == DEB_MAX) begin
            state_d   = HELD;
            code_d    = {row_q, col_q};
            valid_d   = 1'b1;
            pressed_d = 1'b1;
          end else deb_d = deb_inc;
        HELD:
          if (!hit) begin
            if (DEB_MAX == 4'd1) begin
              state_d   = SCAN;
              pressed_d = 1'b0;
              col_d     = col_nx;
            end else begin
              state_d = RELEASE;
              deb_d   = 4'd1;
            end
          end
        RELEASE:
          if (hit) state_d = HELD;
          else if (deb_inc == DEB_MAX) begin
            state_d   = SCAN;
            pressed_d = 1'b0;
            col_d     = col_nx;
          end else deb_d = deb_inc;
        default: state_d = SCAN;
      endcase
    end
  end
  // state and registered outputs; reset returns to scanning column 0 at once
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      dwell_q   <= 16'd0;
      state_q   <= SCAN;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      deb_q     <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      dwell_q   <= dwell_d;
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      deb_q     <= deb_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
    end
  assign Cols    = col_drive(col_q);
  assign Code    = code_q;
  assign Valid   = valid_q;
  assign Pressed = pressed_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus sample-level reference model checking every cycle
module tb_keypad_scanner;
  localparam int DIV = 4;
  localparam int DBC = 3;
  logic clk = 1'b0, rst;
  logic [3:0] Rows, Cols, Code;
  logic Valid, Pressed;
  keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_CNT(DBC)) dut (
    .Clock  (clk),
    .Reset  (rst),
    .Rows   (Rows),
    .Cols   (Cols),
    .Code   (Code),
    .Valid  (Valid),
    .Pressed(Pressed)
  );
  always #5 clk = ~clk;

  int checks = 0, failures = 0, vpulses = 0;
  logic [15:0] keys;
  logic [3:0] force_low;

  // reference model: sample-level view of the scanning rules
  int m_dwell, m_col, m_row, m_agree, m_rel;
  bit m_track, m_press, m_valid;
  logic [3:0] m_code, s1, s2;

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          hold;
    int          pulses;
    logic [3:0]  code;
    logic [3:0]  cols;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // physical keypad: a closed key pulls its row low while its column is driven low
  function automatic logic [3:0] phys();
    logic [3:0] r = 4'hF;
    for (int i = 0; i < 16; i++) if (keys[i] && !Cols[i%4]) r[i/4] = 1'b0;
    return r & ~force_low;
  endfunction

  task automatic model_reset();
    m_dwell = 0; m_col = 0; m_row = 0; m_agree = 0; m_rel = 0;
    m_track = 0; m_press = 0; m_valid = 0; m_code = 4'd0;
    s1 = 4'hF; s2 = 4'hF;
  endtask

  task automatic confirm();
    m_press = 1; m_valid = 1; m_rel = 0;
    m_code = {m_row[1:0], m_col[1:0]};
  endtask

  task automatic model_edge();
    logic [3:0] lo = ~s2;
    m_valid = 0;
    if (m_dwell == DIV - 1) begin
      if (!m_track) begin
        if (lo != 4'd0) begin
          m_track = 1; m_agree = 1; m_row = 0;
          while (!lo[m_row]) m_row++;
          if (m_agree == DBC) confirm();
        end else m_col = (m_col + 1) % 4;
      end else if (!m_press) begin
        if (lo[m_row]) begin
          m_agree++;
          if (m_agree == DBC) confirm();
        end else begin
          m_track = 0; m_col = (m_col + 1) % 4;
        end
      end else if (!lo[m_row]) begin
        m_rel++;
        if (m_rel == DBC) begin
          m_press = 0; m_track = 0; m_col = (m_col + 1) % 4;
        end
      end else m_rel = 0;
    end
    m_dwell = (m_dwell + 1) % DIV;
    s2 = s1;
    s1 = Rows;
  endtask

  task automatic step();
    logic [3:0] exp_cols;
    @(posedge clk);
    #1;
    model_edge();
    exp_cols = ~(4'b0001 << m_col);
    check("cols", Cols, exp_cols);
    check("code", Code, m_code);
    check("valid", {3'b000, Valid}, {3'b000, m_valid});
    check("pressed", {3'b000, Pressed}, {3'b000, m_press});
    if (Valid) vpulses++;
    Rows = phys();
  endtask

  task automatic wait_pressed();
    int n = 0;
    while (!Pressed && n < 200) begin
      step();
      n++;
    end
    check("wait_pressed", {3'b000, Pressed}, 4'b0001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"key5",  16'h0020, 40, 1, 4'b0101, 4'b1101};
    vecs[1] = '{"keyD",  16'h8000, 20, 1, 4'b1111, 4'b0111};
    vecs[2] = '{"row02", 16'h0101, 20, 1, 4'b0000, 4'b1110};
    vecs[3] = '{"keyA",  16'h0008, 12, 1, 4'b0011, 4'b0111};
    vecs[4] = '{"key4",  16'h0010, 12, 1, 4'b0100, 4'b1110};
    rst = 1'b1; keys = 16'd0; force_low = 4'd0; Rows = 4'hF;
    model_reset();
    #12;
    check("rst_cols", Cols, 4'b1110);
    check("rst_code", Code, 4'b0000);
    check("rst_valid", {3'b000, Valid}, 4'b0000);
    check("rst_pressed", {3'b000, Pressed}, 4'b0000);
    rst = 1'b0;

    foreach (vecs[i]) begin
      vpulses = 0;
      keys = vecs[i].keys;
      repeat (vecs[i].hold * DIV) step();
      check({vecs[i].name, "_held_cols"}, Cols, vecs[i].cols);
      check({vecs[i].name, "_held_pressed"}, {3'b000, Pressed}, 4'b0001);
      keys = 16'd0;
      repeat (12 * DIV) step();
      checki({vecs[i].name, "_pulses"}, vpulses, vecs[i].pulses);
      check({vecs[i].name, "_code"}, Code, vecs[i].code);
      check({vecs[i].name, "_released"}, {3'b000, Pressed}, 4'b0000);
    end

    // one-dwell glitch on row 2 while column 3 is driven
    begin
      int n = 0;
      while (!(m_col == 3 && m_dwell == 0) && n < 64) begin
        step();
        n++;
      end
      checki("glitch_align", m_col, 3);
      vpulses = 0;
      force_low = 4'b0100;
      Rows = phys();
      repeat (3) step();
      force_low = 4'd0;
      repeat (5) step();
      check("glitch_resume_col0", Cols, 4'b1110);
      repeat (8 * DIV) step();
      checki("glitch_pulses", vpulses, 0);
      check("glitch_code", Code, 4'b0100);
    end

    // release bounce: high one sample, low one sample, then high
    keys = 16'h0020;
    wait_pressed();
    vpulses = 0;
    keys = 16'd0;
    repeat (4) step();
    keys = 16'h0020;
    repeat (4) step();
    keys = 16'd0;
    repeat (8) step();
    check("bounce_still_pressed", {3'b000, Pressed}, 4'b0001);
    repeat (8) step();
    check("bounce_released", {3'b000, Pressed}, 4'b0000);
    checki("bounce_pulses", vpulses, 0);
    repeat (4 * DIV) step();

    // asynchronous reset while a key is held
    keys = 16'h8000;
    wait_pressed();
    rst = 1'b1;
    #1;
    check("held_rst_cols", Cols, 4'b1110);
    check("held_rst_code", Code, 4'b0000);
    check("held_rst_valid", {3'b000, Valid}, 4'b0000);
    check("held_rst_pressed", {3'b000, Pressed}, 4'b0000);
    keys = 16'd0;
    model_reset();
    #2;
    rst = 1'b0;
    Rows = phys();
    repeat (8 * DIV) step();

    // random presses, possibly two keys at once, with random hold and gap lengths
    repeat (40) begin
      keys = 16'd1 << $urandom_range(15);
      if ($urandom_range(1) == 1) keys = keys | (16'd1 << $urandom_range(15));
      repeat ($urandom_range(100, 4)) step();
      keys = 16'd0;
      repeat ($urandom_range(60, 1)) step();
    end
    keys = 16'd0;
    repeat (12 * DIV) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning Clock cycles each column is driven per dwell; legal range 4 to 65535.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, meaning consecutive agreeing dwell samples needed to confirm a press or a release; legal range 1 to 15.
REQ-003 Clock  input  1  sole clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Rows  input  4  keypad row lines; active-low with external pull-ups; asynchronous to Clock.
REQ-006 Cols  output  4  keypad column drives; active-low; exactly one bit low at all times.
REQ-007 Code  output  4  key code {row[1:0], col[1:0]}; row 0 is the top row and col 0 the leftmost column ('1' = 4'b0000, 'A' = 4'b0011, '4' = 4'b0100, 'D' = 4'b1111).
REQ-008 Valid  output  1  one-cycle pulse when Code is updated with a newly confirmed press.
REQ-009 Pressed  output  1  high from the confirmed press until the confirmed release.

Function
REQ-010 Rows SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value.
REQ-011 A dwell counter SHALL count 0 to SCAN_DIV-1 and wrap; the sample point is count == SCAN_DIV-1.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-013 SCAN: at each sample point with no synchronized row low, advance the active column 0->1->2->3->0 (Cols 1110->1101->1011->0111->1110).
REQ-014 SCAN: at a sample point with any row low, latch the active column and the lowest-index low row, set debounce count to 1, and enter DEBOUNCE; the column does not advance.
REQ-015 If several rows are low on the same column, the lowest row index wins; keys on other columns are ignored until the FSM returns to SCAN.
REQ-016 DEBOUNCE: at each sample point, if the latched row is low, increment the count; reaching DEBOUNCE_CNT enters HELD.
REQ-017 DEBOUNCE: at a sample point where the latched row is high, return to SCAN and advance the column.
REQ-018 When DEBOUNCE_CNT == 1, the SCAN detection sample itself confirms the press; SCAN goes directly to HELD.
REQ-019 On entering HELD, in the same cycle, Code SHALL take the latched {row, col}, Valid SHALL be high for exactly one cycle, and Pressed SHALL go high.
REQ-020 HELD: the latched column stays driven; a sample with the latched row high enters RELEASE with count 1.
REQ-021 RELEASE: a sample with the latched row high increments the count; reaching DEBOUNCE_CNT sets Pressed low, returns to SCAN and advances the column.
REQ-022 RELEASE: a sample with the latched row low returns to HELD with no Valid pulse.
REQ-023 A held key SHALL produce no further Valid pulses (no auto-repeat).
REQ-024 Code SHALL hold its last value until the next confirmed press.
REQ-025 Latency from Rows going low to Valid, with stable input, SHALL be at most (4 + DEBOUNCE_CNT) x SCAN_DIV + 3 cycles.

Reset
REQ-026 Asserting Reset at any time, including mid-debounce or HELD, SHALL immediately set state = SCAN, Cols = 4'b1110, Code = 4'b0000, Valid = 0, Pressed = 0, and clear the dwell counter, debounce counter and synchronizer.
REQ-027 After Reset deasserts, the first sample point SHALL occur SCAN_DIV cycles later.

Structure
REQ-028 Package keypad_pkg SHALL hold the FSM state typedef, the default SCAN_DIV and DEBOUNCE_CNT values, and the column-drive constants 4'b1110, 4'b1101, 4'b1011 and 4'b0111.
REQ-029 The synchronizer SHALL be a separate sub-module, keypad_sync, with width parameter 4 and reset value 4'b1111.
REQ-030 Code SHALL be directly consumable by the existing key-value decoder without remapping.

Verification (SCAN_DIV = 4, DEBOUNCE_CNT = 3)
REQ-031 Key '5' (row 1 on col 1) held stable -> one Valid pulse, Code = 4'b0101, Pressed = 1, Cols held at 4'b1101.
REQ-032 Row 2 glitches low for 1 dwell on col 3 -> no Valid pulse, Code unchanged, scanning resumes at col 0.
REQ-033 Key 'D' pressed for 20 dwells then released -> exactly one Valid pulse with Code = 4'b1111; Pressed falls 3 samples after release.
REQ-034 Rows 0 and 2 both low on col 0 -> Code = 4'b0000 ('1').
REQ-035 Reset asserted in HELD -> same-cycle outputs Cols = 4'b1110, Code = 0, Valid = 0, Pressed = 0.
REQ-036 Release bounce in RELEASE (row high, low, then high for 3 samples) -> no second Valid pulse; Pressed stays high until the 3rd consecutive high sample.
